// File: rtl/mc_controller_ext.sv
// Multicycle MIPS-style control FSM with bne/addi/j extensions, optional memory
// wait states and a wrapping retired-instruction counter.
module mc_controller_ext #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          EXT_OPS     = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             iord,
  output logic             alu_src_a,
  output logic             ir_write,
  output logic             mem_write,
  output logic             pc_write,
  output logic             branch,
  output logic             branch_ne,
  output logic             reg_write,
  output logic             pc_en,
  output logic             illegal,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_control,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             mem_go;
  logic             is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
  logic             funct_ok;
  logic [2:0]       funct_alu;
  logic             legal;

  // With wait states disabled every memory access completes in one cycle.
  assign mem_go = mem_ready | ~MEM_WAIT_EN;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_addi = (opcode == OP_ADDI);
  assign is_j    = (opcode == OP_J);

  // R-type funct to ALU operation; unlisted functs are illegal.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign legal = (is_r & funct_ok) | is_lw | is_sw | is_beq
               | (EXT_OPS & (is_bne | is_addi | is_j));

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state; retire marks a completing state heading back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:   state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!legal)                state_d = S_FETCH;
        else if (is_lw || is_sw)   state_d = S_MEMADR;
        else if (is_r)             state_d = S_EXECUTE;
        else if (is_beq || is_bne) state_d = S_BRANCH;
        else if (is_addi)          state_d = S_ADDIEX;
        else if (is_j)             state_d = S_JUMP;
        else                       state_d = S_FETCH;
      end
      S_MEMADR:  state_d = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = mem_go ? S_FETCH : S_MEMWR;
        retire  = mem_go;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode of the current state; reset masks every enable.
  always_comb begin
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    iord        = 1'b0;
    alu_src_a   = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_go;
        pc_write    = mem_go;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        illegal     = ~legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = is_beq;
        branch_ne   = is_bne;
      end
      S_ADDIWB:  reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
    pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
    if (reset) pc_en = 1'b0;
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Scoreboard bench: dut 0 uses default parameters, dut 1 has wait states off,
// extended ops off and a 2-bit counter.
module tb_mc_controller_ext;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s     [2];
  logic [5:0] opcode_s    [2];
  logic [5:0] funct_s     [2];
  logic       zero_s      [2];
  logic       mem_ready_s [2];

  logic       mem_to_reg_o [2];
  logic       reg_dst_o    [2];
  logic       iord_o       [2];
  logic       alu_src_a_o  [2];
  logic       ir_write_o   [2];
  logic       mem_write_o  [2];
  logic       pc_write_o   [2];
  logic       branch_o     [2];
  logic       branch_ne_o  [2];
  logic       reg_write_o  [2];
  logic       pc_en_o      [2];
  logic       illegal_o    [2];
  logic [1:0] alu_src_b_o  [2];
  logic [1:0] pc_src_o     [2];
  logic [2:0] alu_control_o[2];
  logic [3:0] state_o      [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  mc_controller_ext dut0 (
    .clk(clk), .reset(reset_s[0]), .opcode(opcode_s[0]), .funct(funct_s[0]),
    .zero(zero_s[0]), .mem_ready(mem_ready_s[0]),
    .mem_to_reg(mem_to_reg_o[0]), .reg_dst(reg_dst_o[0]), .iord(iord_o[0]),
    .alu_src_a(alu_src_a_o[0]), .ir_write(ir_write_o[0]), .mem_write(mem_write_o[0]),
    .pc_write(pc_write_o[0]), .branch(branch_o[0]), .branch_ne(branch_ne_o[0]),
    .reg_write(reg_write_o[0]), .pc_en(pc_en_o[0]), .illegal(illegal_o[0]),
    .alu_src_b(alu_src_b_o[0]), .pc_src(pc_src_o[0]), .alu_control(alu_control_o[0]),
    .state(state_o[0]), .instr_count(cnt0)
  );

  mc_controller_ext #(.MEM_WAIT_EN(1'b0), .EXT_OPS(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset_s[1]), .opcode(opcode_s[1]), .funct(funct_s[1]),
    .zero(zero_s[1]), .mem_ready(mem_ready_s[1]),
    .mem_to_reg(mem_to_reg_o[1]), .reg_dst(reg_dst_o[1]), .iord(iord_o[1]),
    .alu_src_a(alu_src_a_o[1]), .ir_write(ir_write_o[1]), .mem_write(mem_write_o[1]),
    .pc_write(pc_write_o[1]), .branch(branch_o[1]), .branch_ne(branch_ne_o[1]),
    .reg_write(reg_write_o[1]), .pc_en(pc_en_o[1]), .illegal(illegal_o[1]),
    .alu_src_b(alu_src_b_o[1]), .pc_src(pc_src_o[1]), .alu_control(alu_control_o[1]),
    .state(state_o[1]), .instr_count(cnt1)
  );

  typedef struct {
    logic [22:0] sig;
    logic [15:0] cnt;
    int          st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] mcnt    [2];
  logic [5:0]  cur_op  [2];
  logic [5:0]  cur_fn  [2];
  logic        cur_zero[2];

  function automatic bit wait_en(int k);
    return k == 0;
  endfunction

  function automatic bit ext_en(int k);
    return k == 0;
  endfunction

  function automatic logic [15:0] cmask(int k);
    return (k == 0) ? 16'hFFFF : 16'h0003;
  endfunction

  function automatic bit funct_alu(input logic [5:0] fn, output logic [2:0] ctl);
    bit ok = 1'b1;
    ctl = 3'b010;
    case (fn)
      6'b100000: ctl = 3'b010;
      6'b100010: ctl = 3'b110;
      6'b100100: ctl = 3'b000;
      6'b100101: ctl = 3'b001;
      6'b101010: ctl = 3'b111;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic bit legal(int k, logic [5:0] op, logic [5:0] fn);
    logic [2:0] c;
    if (op == OP_R) return funct_alu(fn, c);
    if (op == OP_LW || op == OP_SW || op == OP_BEQ) return 1'b1;
    if (op == OP_BNE || op == OP_ADDI || op == OP_J) return ext_en(k);
    return 1'b0;
  endfunction

  // Expected output vector for one cycle, straight from the per-state output table.
  function automatic logic [22:0] exp_sig(int k, int st, logic [5:0] op, logic [5:0] fn,
                                          logic z, logic rdy, logic rst);
    logic m2r, rdst, io, asa, irw, mw, pcw, br, brn, rw, pce, ill, ok;
    logic [1:0] asb, psrc;
    logic [2:0] ctl;
    {m2r, rdst, io, asa, irw, mw, pcw, br, brn, rw, ill} = 11'b0;
    asb = 2'b00; psrc = 2'b00; ctl = 3'b000;
    case (st)
      0: begin asb = 2'b01; ctl = 3'b010; irw = rdy | !wait_en(k); pcw = irw; end
      1: begin asb = 2'b11; ctl = 3'b010; ill = !legal(k, op, fn); end
      2, 9: begin asa = 1'b1; asb = 2'b10; ctl = 3'b010; end
      3: io = 1'b1;
      4: begin m2r = 1'b1; rw = 1'b1; end
      5: begin io = 1'b1; mw = 1'b1; end
      6: begin asa = 1'b1; ok = funct_alu(fn, ctl); end
      7: begin rdst = 1'b1; rw = 1'b1; end
      8: begin asa = 1'b1; ctl = 3'b110; psrc = 2'b01; br = (op == OP_BEQ); brn = (op == OP_BNE); end
      10: rw = 1'b1;
      11: begin psrc = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    pce = pcw | (br & z) | (brn & !z);
    if (rst) begin irw = 1'b0; pcw = 1'b0; mw = 1'b0; rw = 1'b0; pce = 1'b0; ill = 1'b0; end
    return {4'(st), m2r, rdst, io, asa, irw, mw, pcw, br, brn, rw, pce, ill, asb, psrc, ctl};
  endfunction

  function automatic logic [22:0] obs(int k);
    return {state_o[k], mem_to_reg_o[k], reg_dst_o[k], iord_o[k], alu_src_a_o[k],
            ir_write_o[k], mem_write_o[k], pc_write_o[k], branch_o[k], branch_ne_o[k],
            reg_write_o[k], pc_en_o[k], illegal_o[k], alu_src_b_o[k], pc_src_o[k],
            alu_control_o[k]};
  endfunction

  function automatic void check(int k, exp_t e);
    logic [22:0] got = obs(k);
    logic [15:0] gc  = (k == 0) ? cnt0 : 16'(cnt1);
    n_tests++;
    if (got !== e.sig) begin
      n_fail++;
      $display("FAIL dut%0d st%0d outputs got %h want %h", k, e.st, got, e.sig);
    end
    n_tests++;
    if (gc !== e.cnt) begin
      n_fail++;
      $display("FAIL dut%0d st%0d instr_count got %0d want %0d", k, e.st, gc, e.cnt);
    end
  endfunction

  // Monitors: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q0.size() != 0) check(0, q0.pop_front());
    if (q1.size() != 0) check(1, q1.pop_front());
  end

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic cyc(int k, int st, logic rdy, logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset_s[k]     = rst;
    mem_ready_s[k] = rdy;
    opcode_s[k]    = cur_op[k];
    funct_s[k]     = cur_fn[k];
    zero_s[k]      = cur_zero[k];
    e.sig = exp_sig(k, st, cur_op[k], cur_fn[k], cur_zero[k], rdy, rst);
    e.cnt = mcnt[k];
    e.st  = st;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step(int k, int st, logic rdy, int abort_at, inout int idx, inout bit ab);
    if (ab) return;
    if (idx == abort_at) begin
      cyc(k, st, rdy, 1'b1);
      mcnt[k] = 16'h0;
      ab = 1'b1;
    end else begin
      cyc(k, st, rdy, 1'b0);
    end
    idx++;
  endtask

  // Memory-waiting state: stalls with mem_ready low, then one ready cycle.
  task automatic wstate(int k, int st, int stalls, int abort_at, inout int idx, inout bit ab);
    if (wait_en(k)) begin
      for (int i = 0; i < stalls; i++) step(k, st, 1'b0, abort_at, idx, ab);
      step(k, st, 1'b1, abort_at, idx, ab);
    end else begin
      step(k, st, 1'b0, abort_at, idx, ab);
    end
  endtask

  task automatic run_instr(int k, logic [5:0] op, logic [5:0] fn, logic z,
                           int fst, int mst, int abort_at);
    int idx = 0;
    bit ab  = 1'b0;
    int path[$];
    cur_op[k] = op; cur_fn[k] = fn; cur_zero[k] = z;
    wstate(k, 0, fst, abort_at, idx, ab);
    step(k, 1, 1'($urandom), abort_at, idx, ab);
    if (ab || !legal(k, op, fn)) return;
    case (op)
      OP_R:           begin path.push_back(6); path.push_back(7); end
      OP_LW:          begin path.push_back(2); path.push_back(3); path.push_back(4); end
      OP_SW:          begin path.push_back(2); path.push_back(5); end
      OP_BEQ, OP_BNE: path.push_back(8);
      OP_ADDI:        begin path.push_back(9); path.push_back(10); end
      default:        path.push_back(11);
    endcase
    foreach (path[i]) begin
      if (path[i] == 3 || path[i] == 5) wstate(k, path[i], mst, abort_at, idx, ab);
      else step(k, path[i], 1'($urandom), abort_at, idx, ab);
    end
    if (!ab) mcnt[k] = (mcnt[k] + 16'd1) & cmask(k);
  endtask

  task automatic rand_instr(int k);
    logic [5:0] op, fn;
    int abort_at;
    case ($urandom_range(0, 8))
      0, 8: op = OP_R;
      1: op = OP_LW;
      2: op = OP_SW;
      3: op = OP_BEQ;
      4: op = OP_BNE;
      5: op = OP_ADDI;
      6: op = OP_J;
      default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: fn = 6'b100000;
      1: fn = 6'b100010;
      2: fn = 6'b100100;
      3: fn = 6'b100101;
      4: fn = 6'b101010;
      default: fn = 6'($urandom);
    endcase
    abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
    run_instr(k, op, fn, 1'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), abort_at);
  endtask

  task automatic drive(int k);
    cyc(k, 0, 1'b0, 1'b1);
    if (k == 0) begin
      run_instr(0, OP_LW,   6'd0,      1'b0, 0, 0, -1);
      run_instr(0, OP_SW,   6'd0,      1'b0, 0, 3, -1);
      run_instr(0, OP_BNE,  6'd0,      1'b0, 0, 0, -1);
      run_instr(0, OP_BNE,  6'd0,      1'b1, 0, 0, -1);
      run_instr(0, OP_BEQ,  6'd0,      1'b0, 0, 0, -1);
      run_instr(0, OP_BEQ,  6'd0,      1'b1, 0, 0, -1);
      run_instr(0, OP_R,    6'b101010, 1'b0, 0, 0, -1);
      run_instr(0, OP_R,    6'b000000, 1'b0, 0, 0, -1);
      run_instr(0, OP_R,    6'b100010, 1'b0, 1, 0, -1);
      run_instr(0, OP_ADDI, 6'd0,      1'b0, 0, 0, -1);
      run_instr(0, OP_J,    6'd0,      1'b1, 2, 0, -1);
      run_instr(0, 6'b111111, 6'd0,    1'b0, 0, 0, -1);
      run_instr(0, OP_LW,   6'd0,      1'b0, 0, 3, 4);
      run_instr(0, OP_LW,   6'd0,      1'b0, 0, 1, -1);
    end else begin
      run_instr(1, OP_ADDI, 6'd0,      1'b0, 0, 0, -1);
      run_instr(1, OP_LW,   6'd0,      1'b0, 0, 0, -1);
      run_instr(1, OP_SW,   6'd0,      1'b0, 0, 0, -1);
      run_instr(1, OP_BNE,  6'd0,      1'b0, 0, 0, -1);
      run_instr(1, OP_J,    6'd0,      1'b0, 0, 0, -1);
      for (int i = 0; i < 4; i++) run_instr(1, OP_BEQ, 6'd0, 1'(i), 0, 0, -1);
      run_instr(1, OP_R,    6'b100100, 1'b0, 0, 0, -1);
    end
    for (int i = 0; i < 150; i++) rand_instr(k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_s[k] = 1'b1; opcode_s[k] = 6'd0; funct_s[k] = 6'd0;
      zero_s[k] = 1'b0; mem_ready_s[k] = 1'b0; mcnt[k] = 16'd0;
      cur_op[k] = 6'd0; cur_fn[k] = 6'd0; cur_zero[k] = 1'b0;
    end
    fork
      drive(0);
      drive(1);
    join
    repeat (3) @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
